// File: rtl/oven_pkg.sv
// Shared types and constants for the oven keypad entry controller.
package oven_pkg;

    typedef enum logic [1:0] {
        ST_OFF  = 2'd0,
        ST_TEMP = 2'd1,
        ST_TIME = 2'd2,
        ST_RUN  = 2'd3
    } oven_state_e;

    typedef logic [3:0] bcd_digit_t;

    localparam int MIN_TEMP_DEF = 100;
    localparam int MAX_TEMP_DEF = 550;
    localparam int SEC_PER_MIN  = 60;

    function automatic int bcd_pair(input bcd_digit_t hi, input bcd_digit_t lo);
        return int'(hi) * 10 + int'(lo);
    endfunction

endpackage

// File: rtl/oven_entry_ctrl_key_edge_sync.sv
// Two-flop synchronizer with rising-edge detect for one keypad strobe.
// Only built when OVEN_ENTRY_KEYSYNC_EN is defined.
`ifdef OVEN_ENTRY_KEYSYNC_EN
module key_edge_sync (
    input  logic clk,
    input  logic reset,
    input  logic key_async,
    output logic key_pulse
);

    logic sync_q1;
    logic sync_q2;
    logic sync_prev;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q1   <= 1'b0;
            sync_q2   <= 1'b0;
            sync_prev <= 1'b0;
        end else begin
            sync_q1   <= key_async;
            sync_q2   <= sync_q1;
            sync_prev <= sync_q2;
        end
    end

    // A held key yields exactly one pulse on its leading edge.
    assign key_pulse = sync_q2 & ~sync_prev;

endmodule
`endif

// File: rtl/oven_entry_ctrl.sv
// Keypad entry controller: BCD temperature and MM:SS time entry for the oven display.
// Define OVEN_ENTRY_KEYSYNC_EN to synchronize and edge-detect the key strobes.
//
// state   | meaning
// --------+--------------------------------------------------
// ST_OFF  | power low; fields wiped, waiting for power
// ST_TEMP | entering 3-digit target temperature
// ST_TIME | entering 4-digit MM:SS cook time
// ST_RUN  | both committed; outputs frozen until clear or power-off
module oven_entry_ctrl
    import oven_pkg::*;
#(
    parameter int MIN_TEMP = MIN_TEMP_DEF,
    parameter int MAX_TEMP = MAX_TEMP_DEF,
    parameter int TEMP_W   = 10,
    parameter int TIME_W   = 13
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              power,
    input  logic              digit_valid,
    input  logic [3:0]        digit,
    input  logic              key_enter,
    input  logic              key_clear,
    output logic [TEMP_W-1:0] target_temp,
    output logic [TIME_W-1:0] target_time,
    output logic              tempInputDone,
    output logic              timeInputDone,
    output logic              entry_error
);

    logic       dig_stb;
    logic       ent_stb;
    logic       clr_stb;
    bcd_digit_t dig_val;

`ifdef OVEN_ENTRY_KEYSYNC_EN
    bcd_digit_t digit_d1;
    bcd_digit_t digit_d2;

    key_edge_sync u_sync_digit (
        .clk       (clk),
        .reset     (reset),
        .key_async (digit_valid),
        .key_pulse (dig_stb)
    );

    key_edge_sync u_sync_enter (
        .clk       (clk),
        .reset     (reset),
        .key_async (key_enter),
        .key_pulse (ent_stb)
    );

    key_edge_sync u_sync_clear (
        .clk       (clk),
        .reset     (reset),
        .key_async (key_clear),
        .key_pulse (clr_stb)
    );

    // Digit value travels alongside its strobe through the same two stages.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            digit_d1 <= '0;
            digit_d2 <= '0;
        end else begin
            digit_d1 <= digit;
            digit_d2 <= digit_d1;
        end
    end

    assign dig_val = digit_d2;
`else
    assign dig_stb = digit_valid;
    assign ent_stb = key_enter;
    assign clr_stb = key_clear;
    assign dig_val = digit;
`endif

    oven_state_e state;
    oven_state_e state_next;

    bcd_digit_t t2, t1, t0;
    bcd_digit_t m1, m0, s1, s0;

    logic dig_ok;
    int   temp_value;
    int   time_value;
    logic temp_ok;
    logic time_ok;

    assign dig_ok     = dig_stb && (dig_val <= 4'd9);
    assign temp_value = int'(t2) * 100 + bcd_pair(t1, t0);
    assign time_value = bcd_pair(m1, m0) * SEC_PER_MIN + bcd_pair(s1, s0);
    assign temp_ok    = (temp_value >= MIN_TEMP) && (temp_value <= MAX_TEMP);
    assign time_ok    = (s1 <= 4'd5) && (|{m1, m0, s1, s0});

    logic wipe_fields;
    logic temp_zero;
    logic temp_shift;
    logic time_zero;
    logic time_shift;
    logic set_temp_done;
    logic set_time_done;
    logic clr_done;
    logic reject;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_OFF;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (!power) begin
            state_next = ST_OFF;
        end else begin
            case (state)
                ST_OFF:  state_next = ST_TEMP;
                ST_TEMP: if (!clr_stb && ent_stb && temp_ok) state_next = ST_TIME;
                ST_TIME: if (!clr_stb && ent_stb && time_ok) state_next = ST_RUN;
                ST_RUN:  if (clr_stb) state_next = ST_TEMP;
                default: state_next = ST_OFF;
            endcase
        end
    end

    // Key priority: clear beats enter beats digit; a digit alongside a key is dropped.
    always_comb begin
        wipe_fields   = 1'b0;
        temp_zero     = 1'b0;
        temp_shift    = 1'b0;
        time_zero     = 1'b0;
        time_shift    = 1'b0;
        set_temp_done = 1'b0;
        set_time_done = 1'b0;
        clr_done      = 1'b0;
        reject        = 1'b0;
        if (!power) begin
            wipe_fields = 1'b1;
            clr_done    = 1'b1;
        end else begin
            case (state)
                ST_TEMP: begin
                    if (clr_stb) begin
                        temp_zero = 1'b1;
                    end else if (ent_stb) begin
                        set_temp_done = temp_ok;
                        reject        = ~temp_ok;
                    end else if (dig_ok) begin
                        temp_shift = 1'b1;
                    end
                end
                ST_TIME: begin
                    if (clr_stb) begin
                        time_zero = 1'b1;
                    end else if (ent_stb) begin
                        set_time_done = time_ok;
                        reject        = ~time_ok;
                    end else if (dig_ok) begin
                        time_shift = 1'b1;
                    end
                end
                ST_RUN: begin
                    if (clr_stb) clr_done = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            t2 <= '0;
            t1 <= '0;
            t0 <= '0;
        end else if (wipe_fields || temp_zero) begin
            t2 <= '0;
            t1 <= '0;
            t0 <= '0;
        end else if (temp_shift) begin
            t2 <= t1;
            t1 <= t0;
            t0 <= dig_val;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            m1 <= '0;
            m0 <= '0;
            s1 <= '0;
            s0 <= '0;
        end else if (wipe_fields || time_zero) begin
            m1 <= '0;
            m0 <= '0;
            s1 <= '0;
            s0 <= '0;
        end else if (time_shift) begin
            m1 <= m0;
            m0 <= s1;
            s1 <= s0;
            s0 <= dig_val;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tempInputDone <= 1'b0;
            timeInputDone <= 1'b0;
            entry_error   <= 1'b0;
        end else begin
            entry_error <= reject;
            if (clr_done) begin
                tempInputDone <= 1'b0;
                timeInputDone <= 1'b0;
            end else begin
                if (set_temp_done) tempInputDone <= 1'b1;
                if (set_time_done) timeInputDone <= 1'b1;
            end
        end
    end

    // Binary outputs trail the BCD registers by one edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            target_temp <= '0;
            target_time <= '0;
        end else begin
            target_temp <= TEMP_W'(temp_value);
            target_time <= TIME_W'(time_value);
        end
    end

endmodule
